// File: rtl/eth_tx_frame_arbiter_if.sv
// AXI-stream bundle for the TX frame arbiter: PORTS byte-wide requester streams in, one MAC stream out.
interface eth_tx_frame_arbiter_if #(
    parameter int PORTS = 4
);
    logic [8*PORTS-1:0] s_axis_tdata;
    logic [PORTS-1:0]   s_axis_tvalid;
    logic [PORTS-1:0]   s_axis_tready;
    logic [PORTS-1:0]   s_axis_tlast;
    logic [PORTS-1:0]   s_axis_tuser;
    logic [7:0]         m_axis_tdata;
    logic               m_axis_tvalid;
    logic               m_axis_tready;
    logic               m_axis_tlast;
    logic               m_axis_tuser;

    // master: the surrounding requesters and MAC FIFO; slave: the arbiter itself
    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
    );
    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
    );
endinterface

// File: rtl/eth_tx_frame_arbiter.sv
// Frame-granular round-robin arbiter onto the MAC TX stream, with max-length truncation
// and an optional idle gap between frames.
module eth_tx_frame_arbiter #(
    parameter int PORTS         = 4,
    parameter int MAX_FRAME_LEN = 1522,
    parameter int GAP_CYCLES    = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    eth_tx_frame_arbiter_if.slave axis,
    output logic [PORTS-1:0]      grant,
    output logic                  busy,
    output logic                  frame_abort
);
    localparam int IDX_W = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam int CNT_W = $clog2(MAX_FRAME_LEN + 1);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_FRAME_LEN - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, XFER, DROP, GAP} state_t;

    state_t           state;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] rr_ptr;
    logic [CNT_W-1:0] byte_cnt;
    logic [GAP_W-1:0] gap_cnt;

    logic [IDX_W-1:0] winner;
    logic             found;
    logic [IDX_W-1:0] owner_next;
    logic [7:0]       sel_data;
    logic             sel_valid;
    logic             sel_last;
    logic             sel_user;
    logic             at_limit;
    logic             force_end;
    logic             hs;
    logic             end_frame;

    // First requester at or after rr_ptr, wrapping modulo PORTS.
    always_comb begin
        int idx;
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < PORTS; k++) begin
            idx = (int'(rr_ptr) + k) % PORTS;
            if (!found && axis.s_axis_tvalid[idx]) begin
                found  = 1'b1;
                winner = IDX_W'(idx);
            end
        end
    end

    assign owner_next = (owner == IDX_W'(PORTS - 1)) ? '0 : owner + IDX_W'(1);
    assign sel_data   = axis.s_axis_tdata[{owner, 3'b000} +: 8];
    assign sel_valid  = axis.s_axis_tvalid[owner];
    assign sel_last   = axis.s_axis_tlast[owner];
    assign sel_user   = axis.s_axis_tuser[owner];
    assign at_limit   = (byte_cnt == CNT_LAST);
    assign force_end  = at_limit && !sel_last;
    assign hs         = (state == XFER) && sel_valid && axis.m_axis_tready;
    assign end_frame  = (hs && sel_last) || ((state == DROP) && sel_valid && sel_last);
    assign busy       = (state != IDLE);

    // Zero-latency pass-through of the owner; the beat at the length limit is forced to end bad.
    always_comb begin
        axis.s_axis_tready = '0;
        axis.m_axis_tdata  = '0;
        axis.m_axis_tvalid = 1'b0;
        axis.m_axis_tlast  = 1'b0;
        axis.m_axis_tuser  = 1'b0;
        case (state)
            XFER: begin
                axis.m_axis_tdata         = sel_data;
                axis.m_axis_tvalid        = sel_valid;
                axis.m_axis_tlast         = sel_last | force_end;
                axis.m_axis_tuser         = sel_user | force_end;
                axis.s_axis_tready[owner] = axis.m_axis_tready;
            end
            DROP:    axis.s_axis_tready[owner] = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, so it is tested inside the clocked block rather than in the sensitivity list.
        if (!rst_n) begin
            state       <= IDLE;
            owner       <= '0;
            grant       <= '0;
            rr_ptr      <= '0;
            byte_cnt    <= '0;
            gap_cnt     <= '0;
            frame_abort <= 1'b0;
        end else begin
            frame_abort <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        owner <= winner;
                        grant <= PORTS'(1) << winner;
                        state <= XFER;
                    end
                end
                XFER: begin
                    if (hs && sel_last) begin
                        rr_ptr <= owner_next;
                    end else if (hs && at_limit) begin
                        frame_abort <= 1'b1;
                        rr_ptr      <= owner_next;
                        state       <= DROP;
                    end else if (hs) begin
                        byte_cnt <= byte_cnt + CNT_W'(1);
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) state <= IDLE;
                    else                     gap_cnt <= gap_cnt + GAP_W'(1);
                end
                default: ;
            endcase
            // Common frame close for both a normal tlast and the end of a dropped tail.
            if (end_frame) begin
                byte_cnt <= '0;
                gap_cnt  <= '0;
                grant    <= '0;
                if (GAP_CYCLES > 0) state <= GAP;
                else                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Self-checking bench for eth_tx_frame_arbiter: single-frame vector table plus
// hand-written sequences for reset, fairness, stalls, overlength, gap and mid-frame reset.
module tb_eth_tx_frame_arbiter;
    localparam int PORTS   = 4;
    localparam int MAX_LEN = 100;
    localparam int GAP     = 12;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [PORTS-1:0] grant;
    logic             busy;
    logic             frame_abort;

    eth_tx_frame_arbiter_if #(.PORTS(PORTS)) bus ();

    eth_tx_frame_arbiter #(
        .PORTS(PORTS), .MAX_FRAME_LEN(MAX_LEN), .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .axis(bus),
        .grant(grant), .busy(busy), .frame_abort(frame_abort)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [7:0] data; logic last; logic user;} beat_t;
    typedef struct {int port; int len; bit user;} frm_t;
    typedef struct {int port; int len; bit user; bit stall; int out_len; bit out_user; int aborts;} vec_t;

    int    n_cmp = 0;
    int    n_fail = 0;
    int    frames_left[PORTS];
    int    flen[PORTS];
    int    bidx[PORTS];
    int    stall[PORTS];
    bit    src_user[PORTS];
    bit    gap_en[PORTS];
    bit    acc[PORTS];
    bit    mt_toggle = 0;
    beat_t out_q[$];
    frm_t  exp_q[$];
    int    abort_cnt = 0;
    int    cyc = 0;
    int    last_end_cyc = 0;
    bit    prev_last = 0;
    bit    last_seen = 0;
    int    gap_seen = -1;
    vec_t  vecs[8];

    function automatic logic [7:0] exp_byte(input int p, input int i);
        return 8'((p * 37 + i * 5 + 1) & 255);
    endfunction

    function automatic bit srcs_empty();
        for (int p = 0; p < PORTS; p++) if (frames_left[p] != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic drive_src();
        for (int p = 0; p < PORTS; p++) begin
            bus.s_axis_tvalid[p]        = (frames_left[p] > 0) && (stall[p] == 0);
            bus.s_axis_tdata[8*p +: 8]  = exp_byte(p, bidx[p]);
            bus.s_axis_tlast[p]         = (bidx[p] == flen[p] - 1);
            bus.s_axis_tuser[p]         = src_user[p] && (bidx[p] == flen[p] - 1);
        end
    endtask

    task automatic load(input int p, input int n, input int len, input bit usr, input bit stl);
        frames_left[p] = n;
        flen[p]        = len;
        bidx[p]        = 0;
        stall[p]       = 0;
        src_user[p]    = usr;
        gap_en[p]      = stl;
    endtask

    // One clock: advance sources just after the edge, then sample everything on the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
        for (int p = 0; p < PORTS; p++) begin
            if (stall[p] > 0) stall[p]--;
            if (acc[p]) begin
                bidx[p]++;
                if (bidx[p] == flen[p]) begin
                    bidx[p] = 0;
                    frames_left[p]--;
                end else if (gap_en[p] && (bidx[p] % 5 == 2)) begin
                    stall[p] = 2;
                end
            end
        end
        bus.m_axis_tready = mt_toggle ? ~bus.m_axis_tready : 1'b1;
        drive_src();
        @(negedge clk);
        cyc++;
        for (int p = 0; p < PORTS; p++) acc[p] = bus.s_axis_tvalid[p] && bus.s_axis_tready[p];
        if (rst_n && bus.m_axis_tvalid && bus.m_axis_tready) begin
            out_q.push_back('{bus.m_axis_tdata, bus.m_axis_tlast, bus.m_axis_tuser});
            if (prev_last) gap_seen = cyc - last_end_cyc - 1;
            prev_last = bus.m_axis_tlast;
            if (bus.m_axis_tlast) begin
                last_end_cyc = cyc;
                last_seen    = 1'b1;
            end
        end
        if (frame_abort) abort_cnt++;
    endtask

    task automatic run_until_idle(input string name, input int bound);
        int n;
        n = 0;
        step();
        while (!(srcs_empty() && !busy) && n < bound) begin
            step();
            n++;
        end
        check({name, " completes"}, int'(n < bound), 1);
    endtask

    // Splits the captured output into frames and compares each against the expected list.
    task automatic check_frames(input string name);
        int pos;
        int n;
        bit data_ok;
        bit usr;
        pos = 0;
        foreach (exp_q[k]) begin
            n = 0;
            data_ok = 1'b1;
            usr = 1'b0;
            while (pos < out_q.size()) begin
                if (out_q[pos].data != exp_byte(exp_q[k].port, n)) data_ok = 1'b0;
                n++;
                pos++;
                if (out_q[pos-1].last) begin
                    usr = out_q[pos-1].user;
                    break;
                end
            end
            check($sformatf("%s f%0d len", name, k), n, exp_q[k].len);
            check($sformatf("%s f%0d data port%0d", name, k, exp_q[k].port), int'(data_ok), 1);
            check($sformatf("%s f%0d tuser", name, k), int'(usr), int'(exp_q[k].user));
        end
        check({name, " total beats"}, out_q.size(), pos);
        exp_q.delete();
        out_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int viol;
        bit p1_on;
        //          port len  usr stl out  ousr abort
        vecs[0] = '{2,   1,   0,  0,  1,   0,   0};
        vecs[1] = '{3,   64,  0,  0,  64,  0,   0};
        vecs[2] = '{1,   99,  0,  1,  99,  0,   0};
        vecs[3] = '{2,   100, 0,  1,  100, 0,   0};
        vecs[4] = '{3,   100, 1,  0,  100, 1,   0};
        vecs[5] = '{1,   101, 0,  0,  100, 1,   1};
        vecs[6] = '{1,   150, 0,  1,  100, 1,   1};
        vecs[7] = '{0,   30,  1,  1,  30,  1,   0};

        bus.s_axis_tvalid = '0;
        bus.s_axis_tdata  = '0;
        bus.s_axis_tlast  = '0;
        bus.s_axis_tuser  = '0;
        bus.m_axis_tready = 1'b1;
        for (int p = 0; p < PORTS; p++) begin
            load(p, 0, 1, 0, 0);
            acc[p] = 1'b0;
        end

        // Reset held with every port requesting
        for (int p = 0; p < PORTS; p++) load(p, 1, 8, 0, 0);
        drive_src();
        repeat (3) step();
        check("rst grant", grant, 0);
        check("rst busy", busy, 0);
        check("rst m_tvalid", bus.m_axis_tvalid, 0);
        check("rst s_tready", bus.s_axis_tready, 0);
        check("rst m_tlast", bus.m_axis_tlast, 0);
        check("rst m_tuser", bus.m_axis_tuser, 0);
        check("rst frame_abort", frame_abort, 0);
        rst_n = 1'b1;
        step();
        check("release grant", grant, 4'b0001);
        check("release m_tvalid", bus.m_axis_tvalid, 1);
        run_until_idle("t1", 400);
        for (int p = 0; p < PORTS; p++) exp_q.push_back('{p, 8, 0});
        check_frames("t1");

        // Round-robin fairness: 3 x 64-byte frames per port
        for (int p = 0; p < PORTS; p++) load(p, 3, 64, 0, 0);
        drive_src();
        run_until_idle("t2", 3000);
        check("t2 bytes", out_q.size(), 768);
        for (int r = 0; r < 3; r++)
            for (int p = 0; p < PORTS; p++) exp_q.push_back('{p, 64, 0});
        check_frames("t2");

        // Stalls on both sides; port 1 arrives mid-frame and must wait
        load(2, 1, 40, 0, 1);
        mt_toggle = 1'b1;
        drive_src();
        last_seen = 1'b0;
        p1_on = 1'b0;
        viol = 0;
        step();
        check("t3 first grant", grant, 4'b0100);
        for (int n = 0; n < 600 && !last_seen; n++) begin
            step();
            if (!p1_on && bidx[2] >= 10) begin
                load(1, 1, 12, 0, 0);
                drive_src();
                p1_on = 1'b1;
            end
            if (grant != 4'b0100) viol++;
        end
        check("t3 grant held", viol, 0);
        check("t3 tlast seen", int'(last_seen), 1);
        mt_toggle = 1'b0;
        run_until_idle("t3", 600);
        exp_q.push_back('{2, 40, 0});
        exp_q.push_back('{1, 12, 0});
        check_frames("t3");

        // Single-frame vector table
        abort_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            vec_t v;
            string nm;
            v  = vecs[i];
            nm = $sformatf("vec%0d", i);
            load(v.port, 1, v.len, v.user, v.stall);
            mt_toggle = v.stall;
            drive_src();
            run_until_idle(nm, 1500);
            mt_toggle = 1'b0;
            exp_q.push_back('{v.port, v.out_len, v.out_user});
            check_frames(nm);
            check({nm, " aborts"}, abort_cnt, v.aborts);
            abort_cnt = 0;
        end

        // Overlength frame followed by another port's frame
        load(1, 1, 150, 0, 0);
        load(2, 1, 5, 0, 0);
        drive_src();
        run_until_idle("t4", 1000);
        exp_q.push_back('{1, 100, 1});
        exp_q.push_back('{2, 5, 0});
        check_frames("t4");
        check("t4 aborts", abort_cnt, 1);
        abort_cnt = 0;

        // Inter-frame gap: GAP idle cycles plus one arbitration cycle
        load(0, 1, 6, 0, 0);
        load(1, 1, 6, 0, 0);
        drive_src();
        prev_last = 1'b0;
        gap_seen = -1;
        run_until_idle("t5", 400);
        check("t5 idle cycles", gap_seen, GAP + 1);
        exp_q.push_back('{0, 6, 0});
        exp_q.push_back('{1, 6, 0});
        check_frames("t5");

        // Reset at byte 30 of a port-3 frame
        load(3, 1, 60, 0, 0);
        drive_src();
        for (int n = 0; n < 300 && out_q.size() < 30; n++) step();
        rst_n = 1'b0;
        step();
        for (int p = 0; p < PORTS; p++) load(p, 0, 1, 0, 0);
        drive_src();
        check("t6 grant", grant, 0);
        check("t6 busy", busy, 0);
        check("t6 m_tvalid", bus.m_axis_tvalid, 0);
        check("t6 s_tready", bus.s_axis_tready, 0);
        check("t6 partial beats", out_q.size(), 30);
        out_q.delete();
        load(0, 1, 10, 0, 0);
        load(3, 1, 10, 0, 0);
        drive_src();
        step();
        rst_n = 1'b1;
        step();
        check("t6 first grant", grant, 4'b0001);
        run_until_idle("t6", 400);
        exp_q.push_back('{0, 10, 0});
        exp_q.push_back('{3, 10, 0});
        check_frames("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
